button_debouncer: RTL
=====================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The module SHALL declare parameter DEBOUNCE_CYCLES, default 'd250000, meaning the number of clk cycles a synchronized level must hold before it is accepted (legal range 2 to 2^20-1).
REQ-002 The module SHALL declare parameter NUM_BUTTONS, default 4, meaning the number of independent channels (channel 0 = vu, 1 = vd, 2 = hl, 3 = hr).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port btn_raw, input, NUM_BUTTONS bits: asynchronous, bouncing, active-low button pins (0 = pressed).
REQ-006 The module SHALL have port btn_clean, output, NUM_BUTTONS bits: debounced level, active-low (0 = pressed), driven directly into vu_button/vd_button of the player controllers.
REQ-007 The module SHALL have port btn_press, output, NUM_BUTTONS bits: a one-cycle high pulse per accepted press.
REQ-008 The module SHALL have port btn_release, output, NUM_BUTTONS bits: a one-cycle high pulse per accepted release.

Function
REQ-009 Each channel SHALL pass btn_raw through a 2-flop synchronizer (sync1, then sync2); only sync2 SHALL feed the FSM.
REQ-010 Each channel SHALL contain an independent FSM and a counter of $clog2(DEBOUNCE_CYCLES) bits; channels SHALL NOT share state.
REQ-011 The FSM states SHALL be RELEASED, PRESS_CHECK, PRESSED and RELEASE_CHECK.
REQ-012 RELEASED: if sync2 == 0, the FSM SHALL go to PRESS_CHECK with cnt <= 0; otherwise it SHALL stay in RELEASED.
REQ-013 PRESS_CHECK: if sync2 == 1, the FSM SHALL return to RELEASED with no output change (bounce rejected).
REQ-014 PRESS_CHECK: if sync2 == 0 and cnt == DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED, set btn_clean <= 0 and btn_press <= 1 for exactly that cycle.
REQ-015 PRESS_CHECK: if sync2 == 0 and cnt is below DEBOUNCE_CYCLES-1, the FSM SHALL apply cnt <= cnt+1.
REQ-016 PRESSED: if sync2 == 1, the FSM SHALL go to RELEASE_CHECK with cnt <= 0; otherwise it SHALL stay in PRESSED, with no further btn_press pulses however long the button is held.
REQ-017 RELEASE_CHECK: the FSM SHALL mirror REQ-013 to REQ-015 with polarity inverted. If sync2 == 0, it SHALL return to PRESSED. At cnt == DEBOUNCE_CYCLES-1 with sync2 == 1, it SHALL go to RELEASED, set btn_clean <= 1 and pulse btn_release.
REQ-018 btn_clean SHALL change only on PRESS_CHECK→PRESSED and RELEASE_CHECK→RELEASED transitions.
REQ-019 Latency: with edge 1 defined as the first edge sampling a stable raw level, btn_clean SHALL change and the pulse SHALL assert after edge DEBOUNCE_CYCLES+3.
REQ-020 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-021 Simultaneous activity on any combination of channels, including opposing pairs vu/vd, SHALL be processed independently; arbitration belongs to the downstream controllers.
REQ-022 btn_press and btn_release SHALL be registered outputs, never both high on the same channel in the same cycle.

Reset
REQ-023 While rst_n == 0, all outputs SHALL be forced asynchronously to: sync1/sync2 = all 1, FSM = RELEASED, cnt = 0, btn_clean = all 1, btn_press = 0, btn_release = 0.
REQ-024 Reset asserted mid-check or in PRESSED SHALL abort the operation with no pulse emitted.
REQ-025 After rst_n deasserts, a button already held low SHALL be accepted as a new press after the full REQ-019 latency.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026 Reset check: rst_n low with btn_raw = 4'b0000 → btn_clean = 4'b1111, btn_press = btn_release = 0, with no clk required.
REQ-027 Clean press: btn_raw[0] driven low and held → btn_clean[0] = 0 and btn_press[0] = 1 after edge 7, btn_press[0] = 0 from edge 8 on, and exactly one pulse over 100 held cycles.
REQ-028 Bounce rejection: btn_raw[1] low for 3 cycles, high 1 cycle, repeated ×5 → btn_clean[1] stays 1, no btn_press; then held low → accepted after edge 7 counted from the final low.
REQ-029 Release: btn_raw[0] pressed, then driven high → btn_clean[0] = 1 and btn_release[0] = 1 after edge 7 of the high level; a one-cycle low glitch during RELEASE_CHECK keeps btn_clean[0] = 0.
REQ-030 Mid-operation reset: rst_n pulsed low during PRESS_CHECK of channel 2 → no pulse; after release, the held button is accepted after edge 7.
REQ-031 Independence: btn_raw[0] and btn_raw[1] pressed on the same edge, btn_raw[3] pressed 2 cycles later → ch0 and ch1 are accepted together, ch3 is accepted 2 cycles later, and ch2 stays 1.

Source files
------------

// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
//   Bundles the raw button pins and the debounced results of the button
//   debouncer so they travel as one port.
//
//   Signals (all NUM_BUTTONS wide, bit 0 = vu, 1 = vd, 2 = hl, 3 = hr):
//     btn_raw     : raw, asynchronous, bouncing, active-low pins (0 = pressed)
//     btn_clean   : debounced level, active-low (0 = pressed)
//     btn_press   : one-cycle high pulse per accepted press
//     btn_release : one-cycle high pulse per accepted release
//
//   Modports:
//     master : the side that owns the pins and consumes the results
//     slave  : the debouncer itself
//
//   NUM_BUTTONS must match the NUM_BUTTONS of the attached debouncer.
// -----------------------------------------------------------------------------
interface button_debouncer_if #(
    parameter int NUM_BUTTONS = 4
);
    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_clean;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_clean,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_clean,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Per-channel debouncer for active-low push buttons. Each channel runs the
//   raw pin through a 2-flop synchronizer and then through a 4-state FSM that
//   only accepts a new level once it has been seen unchanged for
//   DEBOUNCE_CYCLES consecutive clocks. Channels are fully independent; any
//   arbitration between opposing buttons is left to the consumers.
//
//   Parameters:
//     DEBOUNCE_CYCLES : clocks a synchronized level must hold (2 .. 2^20-1)
//     NUM_BUTTONS     : number of independent channels
//
//   Ports:
//     clk   : system clock, all state updates on its rising edge
//     rst_n : asynchronous active-low reset
//     bus   : button_debouncer_if.slave
//               btn_raw in, btn_clean / btn_press / btn_release out
//
//   Latency: with edge 1 being the first edge that samples a stable raw level,
//   btn_clean changes and the press/release pulse asserts after edge
//   DEBOUNCE_CYCLES+3 (2 synchronizer edges, 1 edge to enter the check state,
//   DEBOUNCE_CYCLES edges of counting).
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 'd250000,
    parameter int NUM_BUTTONS     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debouncer_if.slave   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // Terminal count: the counter stops here, so it can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] RELEASED      = 2'd0;
    localparam logic [1:0] PRESS_CHECK   = 2'd1;
    localparam logic [1:0] PRESSED       = 2'd2;
    localparam logic [1:0] RELEASE_CHECK = 2'd3;

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] clean_level;
    logic [NUM_BUTTONS-1:0] press_pulse;
    logic [NUM_BUTTONS-1:0] release_pulse;
    logic [1:0]             state [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt   [NUM_BUTTONS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle level of an active-low button is 1, so the synchronizer
            // resets high and no phantom press appears after reset.
            sync1         <= '1;
            sync2         <= '1;
            clean_level   <= '1;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;

            // Pulses are single-cycle: cleared every cycle unless re-armed
            // by an accepting transition below.
            press_pulse   <= '0;
            release_pulse <= '0;

            for (int i = 0; i < NUM_BUTTONS; i++) begin
                case (state[i])
                    RELEASED: begin
                        if (!sync2[i]) begin
                            state[i] <= PRESS_CHECK;
                            cnt[i]   <= '0;
                        end
                    end
                    PRESS_CHECK: begin
                        if (sync2[i]) begin
                            // Bounce: fall back without touching outputs.
                            state[i] <= RELEASED;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= PRESSED;
                            clean_level[i] <= 1'b0;
                            press_pulse[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (sync2[i]) begin
                            state[i] <= RELEASE_CHECK;
                            cnt[i]   <= '0;
                        end
                    end
                    RELEASE_CHECK: begin
                        if (!sync2[i]) begin
                            // Glitch while releasing: still held.
                            state[i] <= PRESSED;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]         <= RELEASED;
                            clean_level[i]   <= 1'b1;
                            release_pulse[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i] <= RELEASED;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.btn_clean   = clean_level;
    assign bus.btn_press   = press_pulse;
    assign bus.btn_release = release_pulse;

endmodule
